// File: rtl/ws_array_ctrl.sv
// Sequencer for a ROWS x COLS weight-stationary systolic array: weight load, activation
// streaming, result flagging. All outputs registered; next-cycle values derive from next state.
module ws_array_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_vecs,
  output logic             busy,
  output logic             done,
  output logic             w_rd_en,
  output logic [CNT_W-1:0] w_rd_addr,
  output logic [ROWS-1:0]  load_weight,
  output logic             clear_acc,
  output logic             array_en,
  output logic             act_rd_en,
  output logic [CNT_W-1:0] act_rd_addr,
  output logic             res_valid,
  output logic [CNT_W-1:0] res_wr_addr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOADW   = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W:0]  LAT      = (CNT_W+1)'(ROWS + COLS);
  localparam logic [CNT_W:0]  LAST_ROW = (CNT_W+1)'(ROWS - 1);
  localparam logic [CNT_W:0]  ONE_C    = (CNT_W+1)'(1);
  localparam logic [ROWS-1:0] LW_ONE   = ROWS'(1);

  state_t           state_q, state_d;
  logic [CNT_W:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] n_q, n_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             w_rd_en_q, w_rd_en_d;
  logic [CNT_W-1:0] w_rd_addr_q, w_rd_addr_d;
  logic [ROWS-1:0]  load_weight_q, load_weight_d;
  logic             clear_acc_q, clear_acc_d;
  logic             array_en_q, array_en_d;
  logic             act_rd_en_q, act_rd_en_d;
  logic [CNT_W-1:0] act_rd_addr_q, act_rd_addr_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] res_wr_addr_q, res_wr_addr_d;

  logic [CNT_W:0]   n_ext_s;
  logic [CNT_W:0]   last_t_s;
  logic [CNT_W:0]   res_end_s;
  logic [CNT_W:0]   res_off_s;

  // Next state and counters; LAT+N arithmetic is one bit wider than N so it never wraps.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    last_t_s = LAT + {1'b0, n_q} - ONE_C;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOADW;
          cnt_d   = '0;
          n_d     = num_vecs;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOADW: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_ROW) begin
          state_d = (n_q == '0) ? S_DONE : S_COMPUTE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_COMPUTE: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == last_t_s) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values for the next cycle, decoded from the next state and counter.
  always_comb begin
    n_ext_s       = {1'b0, n_d};
    res_end_s     = LAT + n_ext_s;
    res_off_s     = cnt_d - LAT;
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    w_rd_en_d     = 1'b0;
    w_rd_addr_d   = '0;
    clear_acc_d   = 1'b0;
    array_en_d    = 1'b0;
    act_rd_en_d   = 1'b0;
    act_rd_addr_d = '0;
    res_valid_d   = 1'b0;
    res_wr_addr_d = '0;
    if (state_d == S_LOADW) begin
      w_rd_en_d   = 1'b1;
      w_rd_addr_d = cnt_d[CNT_W-1:0];
    end else if (state_d == S_COMPUTE) begin
      array_en_d = 1'b1;
      if (cnt_d < n_ext_s) begin
        act_rd_en_d   = 1'b1;
        act_rd_addr_d = cnt_d[CNT_W-1:0];
      end else begin
        act_rd_en_d = 1'b0;
      end
      clear_acc_d = (cnt_d != '0) && (cnt_d <= n_ext_s);
      if ((cnt_d >= LAT) && (cnt_d < res_end_s)) begin
        res_valid_d   = 1'b1;
        res_wr_addr_d = res_off_s[CNT_W-1:0];
      end else begin
        res_valid_d = 1'b0;
      end
    end else begin
      w_rd_en_d = 1'b0;
    end
    // Row select trails the weight read by the buffer latency; an abort drops it too.
    if (w_rd_en_q && (state_d != S_IDLE)) begin
      load_weight_d = LW_ONE << w_rd_addr_q;
    end else begin
      load_weight_d = '0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      n_q           <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      w_rd_en_q     <= 1'b0;
      w_rd_addr_q   <= '0;
      load_weight_q <= '0;
      clear_acc_q   <= 1'b0;
      array_en_q    <= 1'b0;
      act_rd_en_q   <= 1'b0;
      act_rd_addr_q <= '0;
      res_valid_q   <= 1'b0;
      res_wr_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      n_q           <= n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      w_rd_en_q     <= w_rd_en_d;
      w_rd_addr_q   <= w_rd_addr_d;
      load_weight_q <= load_weight_d;
      clear_acc_q   <= clear_acc_d;
      array_en_q    <= array_en_d;
      act_rd_en_q   <= act_rd_en_d;
      act_rd_addr_q <= act_rd_addr_d;
      res_valid_q   <= res_valid_d;
      res_wr_addr_q <= res_wr_addr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign w_rd_en     = w_rd_en_q;
  assign w_rd_addr   = w_rd_addr_q;
  assign load_weight = load_weight_q;
  assign clear_acc   = clear_acc_q;
  assign array_en    = array_en_q;
  assign act_rd_en   = act_rd_en_q;
  assign act_rd_addr = act_rd_addr_q;
  assign res_valid   = res_valid_q;
  assign res_wr_addr = res_wr_addr_q;

endmodule

// File: tb/tb_ws_array_ctrl.sv
// Randomized bench for ws_array_ctrl: a timeline model (outputs as a function of the cycle
// offset since the accepted start) is compared every cycle, plus directed literal pins.
module tb_ws_array_ctrl;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int CNT_W = 16;
  localparam int LAT   = ROWS + COLS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] num_vecs = '0;
  logic             busy, done, w_rd_en, clear_acc, array_en, act_rd_en, res_valid;
  logic [CNT_W-1:0] w_rd_addr, act_rd_addr, res_wr_addr;
  logic [ROWS-1:0]  load_weight;

  int checks = 0;
  int failures = 0;

  // Model: whether a command is in flight, offset k of the current cycle, its N.
  bit m_act = 1'b0;
  int m_k = 0;
  int m_n = 0;

  ws_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_vecs(num_vecs),
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .load_weight(load_weight), .clear_acc(clear_acc), .array_en(array_en),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .res_valid(res_valid),
    .res_wr_addr(res_wr_addr)
  );

  always #5 clk = ~clk;

  function automatic int end_off(int n);
    return (n == 0) ? ROWS + 1 : ROWS + 1 + LAT + n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1'b1;
        m_k   = 1;
        m_n   = int'(num_vecs);
      end
    end else if (abort || m_k == end_off(m_n)) begin
      m_act = 1'b0;
    end else begin
      m_k = m_k + 1;
    end
  end

  // Per-cycle comparison of all outputs against the timeline model.
  always @(posedge clk) begin
    #2;
    begin
      int c0;
      logic e_busy, e_done, e_wen, e_clr, e_aen, e_aren, e_rv;
      logic [CNT_W-1:0] e_wa, e_aa, e_ra, g_wa, g_aa, g_ra;
      logic [ROWS-1:0] e_lw;
      c0 = ROWS + 1;
      e_busy = m_act;
      e_done = m_act && m_k == end_off(m_n);
      e_wen  = m_act && m_k >= 1 && m_k <= ROWS;
      e_wa   = e_wen ? CNT_W'(m_k - 1) : '0;
      e_lw   = (m_act && m_k >= 2 && m_k <= ROWS + 1) ? ROWS'(1 << (m_k - 2)) : '0;
      e_aen  = m_act && m_n > 0 && m_k >= c0 && m_k < c0 + LAT + m_n;
      e_aren = m_act && m_k >= c0 && m_k < c0 + m_n;
      e_aa   = e_aren ? CNT_W'(m_k - c0) : '0;
      e_clr  = m_act && m_k >= c0 + 1 && m_k <= c0 + m_n;
      e_rv   = m_act && m_k >= c0 + LAT && m_k < c0 + LAT + m_n;
      e_ra   = e_rv ? CNT_W'(m_k - c0 - LAT) : '0;
      g_wa = e_wen ? w_rd_addr : '0;
      g_aa = e_aren ? act_rd_addr : '0;
      g_ra = e_rv ? res_wr_addr : '0;
      checks++;
      if ({busy, done, w_rd_en, g_wa, load_weight, clear_acc, array_en, act_rd_en, g_aa, res_valid, g_ra}
          !== {e_busy, e_done, e_wen, e_wa, e_lw, e_clr, e_aen, e_aren, e_aa, e_rv, e_ra}) begin
        failures++;
        $display("FAIL model t=%0t k=%0d n=%0d got busy%b done%b wen%b wa%0d lw%b clr%b aen%b aren%b aa%0d rv%b ra%0d exp busy%b done%b wen%b wa%0d lw%b clr%b aen%b aren%b aa%0d rv%b ra%0d",
                 $time, m_k, m_n, busy, done, w_rd_en, g_wa, load_weight, clear_acc, array_en,
                 act_rd_en, g_aa, res_valid, g_ra, e_busy, e_done, e_wen, e_wa, e_lw, e_clr,
                 e_aen, e_aren, e_aa, e_rv, e_ra);
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pin(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    int rv_cnt;
    int done_cnt;
    #12;
    pin("reset_busy", busy, 0);
    pin("reset_lw", load_weight, 0);
    rst = 1'b0;
    step(2);

    // N=3 nominal timeline, with a stray start during COMPUTE.
    start = 1'b1; num_vecs = 16'd3;
    step(1);
    start = 1'b0;
    pin("n3_busy_c1", busy, 1);
    pin("n3_waddr_c1", w_rd_addr, 0);
    step(1);
    pin("n3_lw_c2", load_weight, 1);
    step(3);
    pin("n3_lw_c5", load_weight, 8);
    pin("n3_aren_c5", act_rd_en, 1);
    pin("n3_aaddr_c5", act_rd_addr, 0);
    step(3);
    start = 1'b1; num_vecs = 16'd7;
    rv_cnt = 0;
    for (int c = 8; c < 16; c++) begin
      step(1);
      start = 1'b0;
      rv_cnt += int'(res_valid);
      if (c + 1 == 13) begin
        pin("n3_rv_c13", res_valid, 1);
        pin("n3_raddr_c13", res_wr_addr, 0);
      end
    end
    pin("n3_done_c16", done, 1);
    pin("n3_rv_count", rv_cnt, 3);
    step(1);
    pin("n3_busy_c17", busy, 0);
    step(2);

    // N=0: four weight reads, done on the fifth cycle.
    start = 1'b1; num_vecs = 16'd0;
    step(1);
    start = 1'b0;
    step(4);
    pin("n0_done_c5", done, 1);
    pin("n0_lw_c5", load_weight, 8);
    pin("n0_aen_c5", array_en, 0);
    step(3);

    // Abort at COMPUTE t=2.
    start = 1'b1; num_vecs = 16'd3;
    step(1);
    start = 1'b0;
    step(6);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    pin("abort_busy", busy, 0);
    pin("abort_aen", array_en, 0);
    pin("abort_aren", act_rd_en, 0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      done_cnt += int'(done);
    end
    pin("abort_no_done", done_cnt, 0);

    // Async reset between edges during LOADW.
    start = 1'b1; num_vecs = 16'd2;
    step(1);
    start = 1'b0;
    step(1);
    #3;
    rst = 1'b1;
    #1;
    pin("arst_busy", busy, 0);
    pin("arst_wen", w_rd_en, 0);
    pin("arst_lw", load_weight, 0);
    step(1);
    rst = 1'b0;
    step(1);

    // Back-to-back, start held high, N=1: done at 14, IDLE at 15, LOADW at 16.
    start = 1'b1; num_vecs = 16'd1;
    step(14);
    pin("b2b_done_c14", done, 1);
    step(1);
    pin("b2b_idle_c15", busy, 0);
    step(1);
    pin("b2b_wen_c16", w_rd_en, 1);
    pin("b2b_waddr_c16", w_rd_addr, 0);
    start = 1'b0;
    step(20);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      abort    = ($urandom_range(0, 60) == 0);
      num_vecs = CNT_W'($urandom_range(0, 6));
      step(1);
    end
    start = 1'b0; abort = 1'b0;
    step(30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
